hc165_scan_ctrl: RTL and testbench

Periodic scan controller and debounce filter for the 74HC165 switch-code reader. It issues start pulses to the `hc165_drive` stage at a fixed interval and consumes that stage's `o_code` / `o_code_valid`. A new 8-bit code is accepted only after `STABLE_CNT` consecutive identical reads. It publishes the debounced code with a change strobe and flags reads that never complete.

---
 rtl/hc165_pkg.sv | 24 ++
 rtl/hc165_scan_ctrl_if.sv | 25 ++
 rtl/scan_debounce.sv | 76 +++++++
 rtl/hc165_scan_ctrl.sv | 137 +++++++++++++
 tb/tb_hc165_scan_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/hc165_pkg.sv
// Shared definitions for the 74HC165 switch-code reader blocks.
package hc165_pkg;

  localparam int HC165_CODE_W = 8;
  localparam logic [HC165_CODE_W-1:0] HC165_CODE_RST = 8'hFF;

  // Scan controller state encoding
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    START      = 2'd1,
    WAIT_VALID = 2'd2,
    WAIT_TICK  = 2'd3
  } scan_state_e;

  // Increment a 4-bit count, holding it once it has reached the limit
  function automatic logic [3:0] sat_inc4(input logic [3:0] val, input logic [3:0] lim);
    if (val >= lim) begin
      return val;
    end else begin
      return val + 4'd1;
    end
  endfunction

endpackage

// File: rtl/hc165_scan_ctrl_if.sv
// Control, driver-handshake and status signals of the scan controller.
interface hc165_scan_ctrl_if;
  import hc165_pkg::*;

  logic                    i_enable;
  logic                    i_clr_err;
  logic                    i_code_valid;
  logic [HC165_CODE_W-1:0] i_code;
  logic                    o_start;
  logic [HC165_CODE_W-1:0] o_stable_code;
  logic                    o_stable_valid;
  logic                    o_code_changed;
  logic                    o_timeout_err;

  modport master (
    output i_enable, i_clr_err, i_code_valid, i_code,
    input  o_start, o_stable_code, o_stable_valid, o_code_changed, o_timeout_err
  );

  modport slave (
    input  i_enable, i_clr_err, i_code_valid, i_code,
    output o_start, o_stable_code, o_stable_valid, o_code_changed, o_timeout_err
  );

endinterface

// File: rtl/scan_debounce.sv
// Debounce filter: a code is published once it has been read STABLE_CNT
// times in a row; a change strobe accompanies every published update.
module scan_debounce
  import hc165_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_sample,
  input  logic [HC165_CODE_W-1:0] i_code,
  input  logic                    i_clr_cnt,
  output logic [HC165_CODE_W-1:0] o_stable_code,
  output logic                    o_stable_valid,
  output logic                    o_code_changed
);

  localparam logic [3:0] MATCH_LIM = 4'(STABLE_CNT);

  logic [HC165_CODE_W-1:0] cand_q, cand_d;
  logic [HC165_CODE_W-1:0] stable_q, stable_d;
  logic [3:0]              match_q, match_d;
  logic                    valid_q, valid_d;
  logic                    changed_q, changed_d;

  // Evaluate a new read against the candidate and decide on qualification
  always_comb begin
    cand_d    = cand_q;
    match_d   = match_q;
    stable_d  = stable_q;
    valid_d   = valid_q;
    changed_d = 1'b0;
    if (i_sample) begin
      if (i_code == cand_q) begin
        match_d = sat_inc4(match_q, MATCH_LIM);
      end else begin
        cand_d  = i_code;
        match_d = 4'd1;
      end
      // Saturated repeats of the already-published code stay silent
      if ((match_d == MATCH_LIM) && ((cand_d != stable_q) || !valid_q)) begin
        stable_d  = cand_d;
        valid_d   = 1'b1;
        changed_d = 1'b1;
      end else begin
        changed_d = 1'b0;
      end
    end else if (i_clr_cnt) begin
      match_d = 4'd0;
    end else begin
      match_d = match_q;
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q    <= HC165_CODE_RST;
      match_q   <= 4'd0;
      stable_q  <= HC165_CODE_RST;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      cand_q    <= cand_d;
      match_q   <= match_d;
      stable_q  <= stable_d;
      valid_q   <= valid_d;
      changed_q <= changed_d;
    end
  end

  assign o_stable_code  = stable_q;
  assign o_stable_valid = valid_q;
  assign o_code_changed = changed_q;

endmodule

// File: rtl/hc165_scan_ctrl.sv
// Periodic scan controller for the hc165_drive stage: issues start pulses
// every SCAN_PERIOD clocks, watches for read completion with a timeout and
// feeds completed reads into the debounce filter.
module hc165_scan_ctrl
  import hc165_pkg::*;
#(
  parameter int SCAN_PERIOD = 50000,
  parameter int STABLE_CNT  = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  hc165_scan_ctrl_if.slave   bus
);

  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
  // The count is written to SCAN_PERIOD-1 on the cycle that leaves for START
  localparam logic [PW-1:0] PERIOD_TURN = PW'(SCAN_PERIOD - 2);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

  scan_state_e   state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] to_q, to_d;
  logic          start_q, start_d;
  logic          err_q, err_d;
  logic          sample_s;
  logic          clr_cnt_s;

  logic [HC165_CODE_W-1:0] stable_code_s;
  logic                    stable_valid_s;
  logic                    code_changed_s;

  // Scan sequencing, period/timeout counting and sticky error flag
  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    to_d      = to_q;
    start_d   = 1'b0;
    sample_s  = 1'b0;
    clr_cnt_s = 1'b0;
    if (bus.i_clr_err) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    if (!bus.i_enable) begin
      // Abandon any in-flight read; its late valid lands outside WAIT_VALID
      state_d   = IDLE;
      period_d  = '0;
      clr_cnt_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          period_d  = '0;
          clr_cnt_s = 1'b1;
          state_d   = START;
          start_d   = 1'b1;
        end
        START: begin
          period_d = '0;
          to_d     = '0;
          state_d  = WAIT_VALID;
        end
        WAIT_VALID: begin
          period_d = period_q + PW'(1);
          to_d     = to_q + TW'(1);
          if (bus.i_code_valid) begin
            // A valid on the terminal-count cycle still wins
            sample_s = 1'b1;
            state_d  = WAIT_TICK;
          end else if (to_q == TO_LAST) begin
            err_d     = 1'b1;
            clr_cnt_s = 1'b1;
            state_d   = WAIT_TICK;
          end else begin
            state_d = WAIT_VALID;
          end
        end
        WAIT_TICK: begin
          if (period_q >= PERIOD_LAST) begin
            period_d = period_q;
          end else begin
            period_d = period_q + PW'(1);
          end
          if (period_q >= PERIOD_TURN) begin
            state_d = START;
            start_d = 1'b1;
          end else begin
            state_d = WAIT_TICK;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Controller registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      period_q <= '0;
      to_q     <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      to_q     <= to_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  scan_debounce #(
    .STABLE_CNT (STABLE_CNT)
  ) u_debounce (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_sample       (sample_s),
    .i_code         (bus.i_code),
    .i_clr_cnt      (clr_cnt_s),
    .o_stable_code  (stable_code_s),
    .o_stable_valid (stable_valid_s),
    .o_code_changed (code_changed_s)
  );

  assign bus.o_start        = start_q;
  assign bus.o_timeout_err  = err_q;
  assign bus.o_stable_code  = stable_code_s;
  assign bus.o_stable_valid = stable_valid_s;
  assign bus.o_code_changed = code_changed_s;

endmodule

// File: tb/tb_hc165_scan_ctrl.sv
// Bench for hc165_scan_ctrl: a driver model answers each start pulse with a
// chosen delay and code; a debounce model based on run lengths of identical
// accepted reads predicts every output on every cycle.
module tb_hc165_scan_ctrl;
  import hc165_pkg::*;

  localparam int P = 200;
  localparam int S = 3;
  localparam int T = 150;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hc165_scan_ctrl_if bus ();

  hc165_scan_ctrl #(
    .SCAN_PERIOD (P),
    .STABLE_CNT  (S),
    .TIMEOUT     (T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  logic [7:0] exp_stable;
  bit         exp_valid;
  bit         exp_chg;
  bit         exp_err;
  int         run_len;
  logic [7:0] run_code;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input bit exp_start);
    chk("o_start",        32'(bus.o_start),        32'(exp_start));
    chk("o_stable_code",  32'(bus.o_stable_code),  32'(exp_stable));
    chk("o_stable_valid", 32'(bus.o_stable_valid), 32'(exp_valid));
    chk("o_code_changed", 32'(bus.o_code_changed), 32'(exp_chg));
    chk("o_timeout_err",  32'(bus.o_timeout_err),  32'(exp_err));
  endtask

  task automatic model_reset();
    exp_stable = 8'hFF;
    exp_valid  = 1'b0;
    exp_chg    = 1'b0;
    exp_err    = 1'b0;
    run_len    = 0;
    run_code   = 8'hFF;
  endtask

  // A code is published once it ends a run of at least S identical reads,
  // unless it is already the published code.
  task automatic accept(input logic [7:0] code);
    if (run_len > 0 && code == run_code) begin
      run_len++;
    end else begin
      run_code = code;
      run_len  = 1;
    end
    if (run_len >= S && (!exp_valid || code != exp_stable)) begin
      exp_stable = code;
      exp_valid  = 1'b1;
      exp_chg    = 1'b1;
    end
  endtask

  // Expect the start pulse on the very next cycle
  task automatic start_now();
    @(negedge clk);
    check_all(1'b1);
    bus.i_code_valid = 1'b0;
    bus.i_clr_err    = 1'b0;
    exp_chg          = 1'b0;
  endtask

  // Run ncyc cycles after a start pulse. dly: cycle of the driver's valid
  // (0 = silent); extra: second stray valid (0 = none); clr_at: >0 pulse
  // clear on that cycle, 0 random clears, <0 none; dis_at: >0 drop enable.
  task automatic do_read(input int dly, input int extra, input logic [7:0] code,
                         input int clr_at, input int dis_at, input int ncyc);
    bit dead;
    bit got;
    bit clr;
    bit tmo;
    got = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      check_all(1'b0);
      dead = (dis_at > 0) && (c > dis_at);
      if (c == dis_at) begin
        bus.i_enable = 1'b0;
        run_len      = 0;
      end
      bus.i_code_valid = (c == dly) || (c == extra);
      bus.i_code       = bus.i_code_valid ? code : 8'($urandom);
      if (clr_at > 0)       clr = (c == clr_at);
      else if (clr_at == 0) clr = ($urandom_range(15) == 0);
      else                  clr = 1'b0;
      bus.i_clr_err = clr;
      exp_chg = 1'b0;
      tmo     = 1'b0;
      if (!dead) begin
        if (c == dly && dly >= 1 && dly <= T) begin
          accept(code);
          got = 1'b1;
        end
        if (c == T && !got) begin
          tmo     = 1'b1;
          run_len = 0;
        end
      end
      exp_err = tmo | (exp_err & !clr);
    end
  endtask

  logic [7:0] seq_codes [5];
  logic [7:0] pool [3];

  initial begin
    logic [7:0] rc;
    int         dly;
    int         extra;

    seq_codes[0] = 8'hA5; seq_codes[1] = 8'h5A; seq_codes[2] = 8'hA5;
    seq_codes[3] = 8'hA5; seq_codes[4] = 8'hA5;
    pool[0] = 8'hA5; pool[1] = 8'h5A; pool[2] = 8'h3C;

    bus.i_enable     = 1'b0;
    bus.i_clr_err    = 1'b0;
    bus.i_code_valid = 1'b0;
    bus.i_code       = 8'h00;
    model_reset();

    // reset state
    repeat (3) @(negedge clk);
    check_all(1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_all(1'b0);

    // first start one cycle after enable; A5 qualifies on the 3rd read only
    bus.i_enable = 1'b1;
    start_now();
    for (int i = 0; i < 4; i++) begin
      do_read(100, 0, 8'hA5, -1, 0, P - 1);
      start_now();
    end

    // silent driver, clear on the timeout cycle: error stays set
    do_read(0, 0, 8'h00, T, 0, P - 1);
    start_now();
    // clear early, then valid exactly on the terminal count: no error
    do_read(T, 0, 8'h5A, 5, 0, P - 1);
    start_now();
    // stray valid in WAIT_TICK must not advance the run
    do_read(60, 170, 8'h5A, -1, 0, P - 1);
    start_now();
    do_read(60, 0, 8'h5A, -1, 0, P - 1);
    start_now();

    // enable dropped mid-read, late valid ignored, then re-enable
    do_read(100, 0, 8'h3C, -1, 10, 150);
    bus.i_enable = 1'b1;
    start_now();

    // randomized reads
    rc = 8'hA5;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(3) == 0) begin
        rc = ($urandom_range(3) == 3) ? 8'($urandom) : pool[$urandom_range(2)];
      end
      dly   = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(T + 20, 1));
      extra = (dly >= 1 && dly <= T && $urandom_range(1) == 1) ? int'($urandom_range(P - 3, T + 1)) : 0;
      do_read(dly, extra, rc, 0, 0, P - 1);
      start_now();
    end

    // reset asserted in the middle of WAIT_VALID
    do_read(0, 0, 8'h00, -1, 0, 50);
    rst_n        = 1'b0;
    bus.i_enable = 1'b0;
    model_reset();
    @(negedge clk);
    check_all(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_all(1'b0);
    end
    bus.i_enable = 1'b1;
    start_now();

    // A5 5A A5 A5 A5: single qualification on the fifth read
    for (int i = 0; i < 5; i++) begin
      do_read(100, 0, seq_codes[i], -1, 0, P - 1);
      start_now();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
